vm80a_intc: RTL
===============

// Module: vm80a_intc
// PURPOSE
//  Vectored interrupt controller: responder side of the vm80a INT/INTA handshake.
//  Latches up to 8 requests, masks and prioritises them, drives the CPU interrupt request.
//  On an INTA status cycle it supplies the RST n opcode for the winning line.
//  Software programs it through an 8-bit Wishbone slave on the system bus, placed next to the UART.
// PARAMETERS
//  EDGE_MASK  8'h00  per line: 1 = rising-edge triggered (latched), 0 = level (follows irq_i)
// PORTS
//  wb_clk_i    in   1  system clock
//  wb_rst_i    in   1  synchronous reset, active-high
//  wb_adr_i    in   2  register select: 0 IMR, 1 IRR, 2 ISR/EOI, 3 CTRL
//  wb_dat_i    in   8  write data
//  wb_dat_o    out  8  read data, valid with wb_ack_o
//  wb_cyc_i    in   1  bus cycle
//  wb_stb_i    in   1  strobe
//  wb_we_i     in   1  write enable
//  wb_ack_o    out  1  single-cycle acknowledge
//  irq_i       in   8  request lines; line 0 = highest priority
//  cpu_sync_i  in   1  CPU SYNC (status byte valid on cpu_dout_i)
//  cpu_dout_i  in   8  CPU data out; bit0 = INTA status during SYNC
//  int_o       out  1  interrupt request to CPU pin_int
//  inta_o      out  1  INTA cycle in progress; steers vec_o onto CPU data-in
//  vec_o       out  8  RST opcode, 8'hC7 | (n<<3)
// BEHAVIOUR
//  Reset values: IMR=0, IRR=0, ISR=0, CTRL=0, int_o=0, inta_o=0, vec_o=8'hFF, wb_ack_o=0, wb_dat_o=0.
//  Edge detect: irq_q <= irq_i each clock. Edge lines set IRR[i] on irq_i & ~irq_q.
//  Level lines: IRR[i] = irq_i (registered, 1-clock latency).
//  Edge set and clear in the same clock: set wins.
//  Requests: req = IRR & IMR. ISR priority level p = index of the lowest set ISR bit (8 if ISR==0).
//  int_o (registered): CTRL[0] & (lowest set bit of req < p). Deasserts in the clock inta_o rises.
//  INTA handshake:
//   - cpu_sync_i=1 & cpu_dout_i[0]=1 -> inta_o=1 next clock.
//   - cpu_sync_i=1 & cpu_dout_i[0]=0 -> inta_o=0 next clock.
//   - In the same clock inta_o rises, select n = lowest set bit of req under the int_o rule.
//     Set vec_o=8'hC7|(n<<3), set ISR[n], clear IRR[n] if line n is edge type.
//   - No qualifying request (spurious, e.g. level dropped) -> vec_o=8'hFF (RST 7); ISR and IRR unchanged.
//   - vec_o holds until the next INTA rise. One vector per INTA cycle; no multi-byte sequences.
//  Wishbone:
//   - wb_ack_o <= cyc & stb & ~wb_ack_o, so ack comes 1 clock after stb and at most every other clock.
//   - Reads are registered with the ack. Write side effects happen on the ack clock.
//   - adr0 IMR  R/W (1 = enabled).
//   - adr1 IRR  R; write 1s clear edge-type pending bits (level bits ignored).
//   - adr2 ISR  R; any write = EOI: clears the lowest set ISR bit. EOI with ISR=0 is a no-op.
//   - adr3 CTRL R/W; bit0 global enable, bit1 auto-EOI (see CONFIGURATION), bits 7:2 read 0.
//  EOI and INTA in the same clock: EOI is applied first, then the new ISR bit is set.
//  wb_rst_i mid-INTA: everything returns to reset values immediately; a CPU still in INTA reads 8'hFF (RST 7).
// CONFIGURATION
//  VM80A_INTC_AUTO_EOI_EN defined:
//   - CTRL[1] is R/W. When CTRL[1]=1, INTA does not set ISR, so the EOI write is unnecessary.
//  Not defined:
//   - CTRL[1] reads 0 and writes are ignored. ISR is always set on INTA.
// TESTING
//  1. Reset, IMR=8'h04, CTRL=1, pulse irq_i[2] (EDGE_MASK=8'h04) -> int_o=1; INTA status 8'h23 -> vec_o=8'hD7, ISR=8'h04, IRR=0, int_o=0.
//  2. With ISR=8'h04, raise irq 5 then irq 1 (IMR=8'hFF) -> no int_o for 5; int_o for 1, vec_o=8'hCF; EOI twice -> ISR=0, then line 5 serviced with vec_o=8'hEF.
//  3. Level line 3 asserted, int_o=1, drop irq_i[3] before INTA -> vec_o=8'hFF, ISR unchanged.
//  4. Edge on line 0 in the same clock as a Wishbone write IRR=8'h01 -> IRR[0] remains 1.
//  5. wb_rst_i during inta_o=1 -> next clock inta_o=0, vec_o=8'hFF, IMR/IRR/ISR/CTRL=0, int_o=0.
//  6. With VM80A_INTC_AUTO_EOI_EN and CTRL=8'h03: INTA on line 6 -> vec_o=8'hF7, ISR stays 0. Without the macro: CTRL reads 8'h01.

Source files
------------

// File: rtl/vm80a_intc.sv
// Vectored interrupt controller answering the vm80a INT/INTA handshake with RST n opcodes.
// Optional macro VM80A_INTC_AUTO_EOI_EN makes CTRL[1] (auto-EOI) writable.
module vm80a_intc #(
    parameter logic [7:0] EDGE_MASK = 8'h00
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic [1:0] wb_adr_i,
    input  logic [7:0] wb_dat_i,
    output logic [7:0] wb_dat_o,
    input  logic       wb_cyc_i,
    input  logic       wb_stb_i,
    input  logic       wb_we_i,
    output logic       wb_ack_o,
    input  logic [7:0] irq_i,
    input  logic       cpu_sync_i,
    input  logic [7:0] cpu_dout_i,
    output logic       int_o,
    output logic       inta_o,
    output logic [7:0] vec_o
);

`ifdef VM80A_INTC_AUTO_EOI_EN
    localparam logic [7:0] CTRL_WMASK = 8'h03;
`else
    localparam logic [7:0] CTRL_WMASK = 8'h01;
`endif

    logic [7:0] irq_q, irq_d;
    logic [7:0] irr_q, irr_d;
    logic [7:0] imr_q, imr_d;
    logic [7:0] isr_q, isr_d;
    logic [7:0] ctrl_q, ctrl_d;
    logic       int_q, int_d;
    logic       inta_q, inta_d;
    logic [7:0] vec_q, vec_d;
    logic       ack_q, ack_d;
    logic [7:0] dat_q, dat_d;

    logic [7:0] req;
    logic [3:0] req_idx, isr_lvl;
    logic [2:0] n;
    logic       wr, qual, inta_rise, auto_eoi;
    logic [7:0] irr_clr, isr_eoi;

    // Index of the lowest set bit; 8 when the vector is empty.
    function automatic logic [3:0] lowest(input logic [7:0] v);
        logic [3:0] r;
        r = 4'd8;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) r = 4'(i);
        end
        return r;
    endfunction

    always_comb begin
        irq_d    = irq_i;
        imr_d    = imr_q;
        ctrl_d   = ctrl_q;
        vec_d    = vec_q;
        dat_d    = dat_q;
        inta_d   = inta_q;
        irr_clr  = 8'h00;
        auto_eoi = 1'b0;
`ifdef VM80A_INTC_AUTO_EOI_EN
        auto_eoi = ctrl_q[1];
`endif

        ack_d = wb_cyc_i & wb_stb_i & ~ack_q;
        wr    = ack_d & wb_we_i;

        req     = irr_q & imr_q;
        req_idx = lowest(req);
        isr_lvl = lowest(isr_q);
        n       = req_idx[2:0];
        qual    = ctrl_q[0] & (req_idx < isr_lvl);

        // Register writes; EOI retires the highest-priority in-service line.
        isr_eoi = isr_q;
        if (wr) begin
            case (wb_adr_i)
                2'd0: imr_d = wb_dat_i;
                2'd1: irr_clr = wb_dat_i & EDGE_MASK;
                2'd2: if (isr_lvl != 4'd8) isr_eoi[isr_lvl[2:0]] = 1'b0;
                default: ctrl_d = wb_dat_i & CTRL_WMASK;
            endcase
        end

        if (ack_d) begin
            case (wb_adr_i)
                2'd0: dat_d = imr_q;
                2'd1: dat_d = irr_q;
                2'd2: dat_d = isr_q;
                default: dat_d = ctrl_q;
            endcase
        end

        if (cpu_sync_i) inta_d = cpu_dout_i[0];
        inta_rise = inta_d & ~inta_q;
        int_d     = qual & ~inta_rise;

        // Vector selection on the INTA rise; a vanished request yields RST 7.
        isr_d = isr_eoi;
        if (inta_rise) begin
            if (qual) begin
                vec_d = 8'hC7 | {2'b00, n, 3'b000};
                if (!auto_eoi) isr_d[n] = 1'b1;
                irr_clr[n] = irr_clr[n] | EDGE_MASK[n];
            end else begin
                vec_d = 8'hFF;
            end
        end

        // Edge set beats any clear in the same clock; level lines just follow irq_i.
        irr_d = ((((irr_q & ~irr_clr) | (irq_i & ~irq_q))) & EDGE_MASK)
              | (irq_i & ~EDGE_MASK);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            irq_q  <= 8'h00;
            irr_q  <= 8'h00;
            imr_q  <= 8'h00;
            isr_q  <= 8'h00;
            ctrl_q <= 8'h00;
            int_q  <= 1'b0;
            inta_q <= 1'b0;
            vec_q  <= 8'hFF;
            ack_q  <= 1'b0;
            dat_q  <= 8'h00;
        end else begin
            irq_q  <= irq_d;
            irr_q  <= irr_d;
            imr_q  <= imr_d;
            isr_q  <= isr_d;
            ctrl_q <= ctrl_d;
            int_q  <= int_d;
            inta_q <= inta_d;
            vec_q  <= vec_d;
            ack_q  <= ack_d;
            dat_q  <= dat_d;
        end
    end

    assign wb_dat_o = dat_q;
    assign wb_ack_o = ack_q;
    assign int_o    = int_q;
    assign inta_o   = inta_q;
    assign vec_o    = vec_q;

endmodule
